// File: rtl/cpu_memory_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
interface cpu_memory_if;
  logic        request;
  logic        rw;
  logic [31:0] address;
  logic [3:0]  byte_enable;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output request, rw, address, byte_enable, wdata,
    input  ready, rdata
  );

  modport slave (
    input  request, rw, address, byte_enable, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/cpu_memory.sv
// Memory pipeline stage: single-outstanding load/store with lane steering,
// load extension, misalignment faults and a bus timeout.
module cpu_memory #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic [7:0]  i_tag,
  input  logic [4:0]  i_inst_rd,
  input  logic [31:0] i_rd,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_mem_address,
  input  logic [2:0]  i_mem_funct3,
  output logic        o_busy,
  output logic [7:0]  o_tag,
  output logic [4:0]  o_inst_rd,
  output logic [31:0] o_rd,
  output logic        o_fault,
  cpu_memory_if.master bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  tag_d;
  logic [4:0]  inst_rd_d;
  logic [31:0] rd_d;
  logic        fault_d;
  logic        req_q, req_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        new_op, mem_op, aligned;
  logic [1:0]  offset;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, shifted, load_value;

  assign new_op = (i_tag != o_tag);
  assign mem_op = i_mem_read | i_mem_write;
  assign offset = i_mem_address[1:0];
  assign o_busy = (state_q == S_WAIT) || (new_op && !i_stall && mem_op);

  assign bus.request     = req_q;
  assign bus.rw          = rw_q;
  assign bus.address     = addr_q;
  assign bus.byte_enable = be_q;
  assign bus.wdata       = wdata_q;

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = i_rd;
    aligned    = 1'b1;
    case (i_mem_funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << offset;
        lane_wdata = {4{i_rd[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << offset;
        lane_wdata = {2{i_rd[15:0]}};
        aligned    = ~offset[0];
      end
      default: aligned = (offset == 2'b00);
    endcase
  end

  // Inputs are held by upstream during WAIT, so the live address/funct3 select the lane.
  always_comb begin
    shifted = bus.rdata >> {offset, 3'b000};
    case (i_mem_funct3)
      3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_value = {24'h000000, shifted[7:0]};
      3'b101:  load_value = {16'h0000, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tag_d     = o_tag;
    inst_rd_d = o_inst_rd;
    rd_d      = o_rd;
    fault_d   = 1'b0;
    req_d     = req_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (new_op && !i_stall) begin
          if (!mem_op) begin
            rd_d      = i_rd;
            inst_rd_d = i_inst_rd;
            tag_d     = i_tag;
          end else if (!aligned) begin
            fault_d   = 1'b1;
            inst_rd_d = '0;
            tag_d     = i_tag;
          end else begin
            req_d   = 1'b1;
            rw_d    = i_mem_write;
            addr_d  = {i_mem_address[31:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_wdata;
            count_d = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.ready) begin
          req_d   = 1'b0;
          tag_d   = i_tag;
          state_d = S_IDLE;
          if (i_mem_write) begin
            inst_rd_d = '0;
          end else begin
            inst_rd_d = i_inst_rd;
            rd_d      = load_value;
          end
        end else if (TIMEOUT_CYCLES != 0 && count_q == TIMEOUT_CYCLES - 1) begin
          req_d     = 1'b0;
          fault_d   = 1'b1;
          inst_rd_d = '0;
          tag_d     = i_tag;
          state_d   = S_IDLE;
        end else begin
          count_d = count_q + 1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      o_tag     <= '0;
      o_inst_rd <= '0;
      o_rd      <= '0;
      o_fault   <= 1'b0;
      req_q     <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      o_tag     <= tag_d;
      o_inst_rd <= inst_rd_d;
      o_rd      <= rd_d;
      o_fault   <= fault_d;
      req_q     <= req_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// Randomized self-checking bench for cpu_memory against an arithmetic reference model.
module tb_cpu_memory;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  tag = '0;
  logic [4:0]  inst_rd = '0;
  logic [31:0] rd = '0;
  logic        mrd = 1'b0, mwr = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  f3 = '0;
  logic        busy;
  logic [7:0]  o_tag;
  logic [4:0]  o_inst_rd;
  logic [31:0] o_rd;
  logic        o_fault;

  always #5 clk = ~clk;

  cpu_memory_if bus ();

  cpu_memory #(.TIMEOUT_CYCLES(4)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_stall(stall), .i_tag(tag),
    .i_inst_rd(inst_rd), .i_rd(rd), .i_mem_read(mrd), .i_mem_write(mwr),
    .i_mem_address(addr), .i_mem_funct3(f3), .o_busy(busy), .o_tag(o_tag),
    .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_fault(o_fault), .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0]  cur_tag = '0;
  logic [7:0]  m_tag = '0;
  logic [4:0]  m_inst = '0;
  logic [31:0] m_rd = '0;
  logic        m_fault = 1'b0;
  logic        exp_req = 1'b0;

  // Observations captured by run_op
  logic        obs_req, obs_rw, obs_req_ok, obs_req_after, obs_fault_after, obs_busy_after;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic [45:0] obs_out;
  int unsigned obs_busy;

  function automatic int unsigned size_of(input logic [2:0] fn);
    if (fn[1:0] == 2'd0) return 1;
    if (fn[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic is_aligned(input logic [31:0] a, input logic [2:0] fn);
    return (a % size_of(fn)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] fn);
    int unsigned n;
    n = size_of(fn);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] fn);
    if (size_of(fn) == 1) return (d % 256) * 32'h01010101;
    if (size_of(fn) == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdat, input logic [31:0] a, input logic [2:0] fn);
    logic [31:0] v;
    logic [31:0] b;
    v = rdat >> (8 * (a % 4));
    case (fn)
      3'd0: begin b = v % 256;   return (b >= 128)   ? b + 32'hFFFFFF00 : b; end
      3'd1: begin b = v % 65536; return (b >= 32768) ? b + 32'hFFFF0000 : b; end
      3'd4: return v % 256;
      3'd5: return v % 65536;
      default: return rdat;
    endcase
  endfunction

  task automatic model_step(input logic [4:0] ird, input logic [31:0] d, input logic r, input logic w,
                            input logic [31:0] a, input logic [2:0] fn, input logic [31:0] rdat);
    m_tag = cur_tag;
    m_fault = 1'b0;
    exp_req = 1'b0;
    if (!(r || w)) begin
      m_rd = d; m_inst = ird;
    end else if (!is_aligned(a, fn)) begin
      m_inst = '0; m_fault = 1'b1;
    end else begin
      exp_req = 1'b1;
      if (w) m_inst = '0;
      else begin m_inst = ird; m_rd = exp_load(rdat, a, fn); end
    end
  endtask

  // Presents one op and records what the DUT does; ready arrives on the wait_n-th WAIT edge.
  task automatic run_op(input logic [4:0] ird, input logic [31:0] d, input logic r, input logic w,
                        input logic [31:0] a, input logic [2:0] fn, input int unsigned wait_n,
                        input logic [31:0] rdat);
    cur_tag = cur_tag + 8'd1;
    tag = cur_tag; inst_rd = ird; rd = d; mrd = r; mwr = w; addr = a; f3 = fn;
    obs_busy = 0; obs_req_ok = 1'b1;
    #1 if (busy) obs_busy++;
    @(posedge clk); #1;
    obs_req = bus.request; obs_rw = bus.rw; obs_addr = bus.address;
    obs_be = bus.byte_enable; obs_wdata = bus.wdata;
    obs_req_after = 1'b0;
    if (bus.request) begin
      for (int unsigned i = 1; i < wait_n; i++) begin
        if (busy) obs_busy++;
        if (!bus.request) obs_req_ok = 1'b0;
        @(posedge clk); #1;
      end
      bus.ready = 1'b1; bus.rdata = rdat;
      if (busy) obs_busy++;
      if (!bus.request) obs_req_ok = 1'b0;
      @(posedge clk); #1;
      bus.ready = 1'b0; bus.rdata = $urandom;
      obs_req_after = bus.request;
    end
    obs_out = {o_tag, o_inst_rd, o_rd, o_fault};
    @(posedge clk); #1;
    obs_fault_after = o_fault;
    obs_busy_after = busy;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({o_tag, o_inst_rd, o_rd, o_fault, bus.request, bus.rw, bus.address, bus.byte_enable, bus.wdata, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: tag=%h rd=%h req=%b busy=%b, all required 0", o_tag, o_rd, bus.request, busy);
    end
  endtask

  task automatic test_pass_through;
    run_op(5'd3, 32'h11111111, 1'b0, 1'b0, 32'h0, 3'd0, 1, 32'h0);
    model_step(5'd3, 32'h11111111, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    run_op(5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 3'd0, 1, 32'h0);
    model_step(5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    tests_run++;
    if (obs_out !== {8'h02, 5'd5, 32'hDEADBEEF, 1'b0} || obs_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_through: out=%h req=%b, required %h req=0", obs_out, obs_req, {8'h02, 5'd5, 32'hDEADBEEF, 1'b0});
    end
  endtask

  task automatic test_load_extend;
    run_op(5'd9, 32'h0, 1'b1, 1'b0, 32'h1003, 3'b000, 3, 32'h80123456);
    model_step(5'd9, 32'h0, 1'b1, 1'b0, 32'h1003, 3'b000, 32'h80123456);
    tests_run++;
    if (obs_be !== 4'b1000 || obs_addr !== 32'h1000 || obs_busy != 4 || obs_rw !== 1'b0) begin
      tests_failed++;
      $display("FAIL lb_request: be=%b addr=%h busy=%0d rw=%b, required 1000 00001000 4 0", obs_be, obs_addr, obs_busy, obs_rw);
    end
    tests_run++;
    if (obs_out !== {m_tag, 5'd9, 32'hFFFFFF80, 1'b0}) begin
      tests_failed++;
      $display("FAIL lb_sign: out=%h required %h", obs_out, {m_tag, 5'd9, 32'hFFFFFF80, 1'b0});
    end
    run_op(5'd9, 32'h0, 1'b1, 1'b0, 32'h1003, 3'b100, 3, 32'h80123456);
    model_step(5'd9, 32'h0, 1'b1, 1'b0, 32'h1003, 3'b100, 32'h80123456);
    tests_run++;
    if (obs_out !== {m_tag, 5'd9, 32'h00000080, 1'b0}) begin
      tests_failed++;
      $display("FAIL lbu_zero: out=%h required %h", obs_out, {m_tag, 5'd9, 32'h00000080, 1'b0});
    end
  endtask

  task automatic test_store_half;
    run_op(5'd12, 32'h0000ABCD, 1'b0, 1'b1, 32'h2002, 3'b001, 2, 32'h12345678);
    model_step(5'd12, 32'h0000ABCD, 1'b0, 1'b1, 32'h2002, 3'b001, 32'h12345678);
    tests_run++;
    if (obs_wdata !== 32'hABCDABCD || obs_be !== 4'b1100 || obs_rw !== 1'b1 || obs_addr !== 32'h2000) begin
      tests_failed++;
      $display("FAIL sh_request: wdata=%h be=%b rw=%b addr=%h, required abcdabcd 1100 1 00002000", obs_wdata, obs_be, obs_rw, obs_addr);
    end
    tests_run++;
    if (obs_out !== {m_tag, 5'd0, m_rd, 1'b0} || obs_req_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL sh_complete: out=%h req=%b, required %h req=0", obs_out, obs_req_after, {m_tag, 5'd0, m_rd, 1'b0});
    end
  endtask

  task automatic test_misaligned;
    run_op(5'd7, 32'h0, 1'b1, 1'b0, 32'h3001, 3'b010, 1, 32'h0);
    model_step(5'd7, 32'h0, 1'b1, 1'b0, 32'h3001, 3'b010, 32'h0);
    tests_run++;
    if (obs_req !== 1'b0 || obs_out !== {m_tag, 5'd0, m_rd, 1'b1} || obs_fault_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL misaligned_lw: req=%b out=%h fault_next=%b, required req=0 out=%h fault_next=0",
               obs_req, obs_out, obs_fault_after, {m_tag, 5'd0, m_rd, 1'b1});
    end
  endtask

  task automatic test_stall;
    logic [31:0] rdat;
    logic [7:0] old_tag;
    rdat = $urandom;
    old_tag = cur_tag;
    cur_tag = cur_tag + 8'd1;
    stall = 1'b1; tag = cur_tag; inst_rd = 5'd20; mrd = 1'b1; mwr = 1'b0; addr = 32'h5000; f3 = 3'b010;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (busy !== 1'b0 || bus.request !== 1'b0 || o_tag !== old_tag) begin
        tests_failed++;
        $display("FAIL stall_hold: busy=%b req=%b tag=%h, required 0 0 %h", busy, bus.request, o_tag, old_tag);
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1; bus.ready = 1'b1; bus.rdata = rdat;
    @(posedge clk); #1;
    bus.ready = 1'b0; stall = 1'b0;
    m_tag = cur_tag; m_inst = 5'd20; m_rd = rdat;
    tests_run++;
    if ({o_tag, o_inst_rd, o_rd} !== {m_tag, m_inst, m_rd} || bus.request !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_in_wait: tag=%h ird=%0d rd=%h req=%b, required %h %0d %h 0", o_tag, o_inst_rd, o_rd, bus.request, m_tag, m_inst, m_rd);
    end
  endtask

  task automatic test_timeout;
    cur_tag = cur_tag + 8'd1;
    tag = cur_tag; inst_rd = 5'd7; mrd = 1'b1; mwr = 1'b0; addr = 32'h6000; f3 = 3'b010;
    @(posedge clk); #1;
    tests_run++;
    if (bus.request !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_start: req=%b required 1", bus.request);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.request !== 1'b1 || o_fault !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_early: cycle %0d req=%b fault=%b, required 1 0", k, bus.request, o_fault);
      end
    end
    @(posedge clk); #1;
    m_tag = cur_tag; m_inst = '0;
    tests_run++;
    if ({bus.request, o_fault, o_inst_rd, o_tag} !== {1'b0, 1'b1, 5'd0, m_tag}) begin
      tests_failed++;
      $display("FAIL timeout_abort: req=%b fault=%b ird=%0d tag=%h, required 0 1 0 %h", bus.request, o_fault, o_inst_rd, o_tag, m_tag);
    end
    @(posedge clk); #1;
    tests_run++;
    if (o_fault !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: fault=%b busy=%b, required 0 0", o_fault, busy);
    end
    run_op(5'd15, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 3'd0, 1, 32'h0);
    model_step(5'd15, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    tests_run++;
    if (obs_out !== {m_tag, m_inst, m_rd, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_recover: out=%h required %h", obs_out, {m_tag, m_inst, m_rd, 1'b0});
    end
  endtask

  task automatic test_random;
    logic [2:0] lf [5];
    logic [2:0] fn;
    logic r, w;
    logic [31:0] a, d, rdat;
    logic [4:0] ird;
    int unsigned kind, wn;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      r = (kind == 1) || (kind == 3);
      w = (kind == 2) || (kind == 3);
      fn = w ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      a = 32'h4000 + 32'($urandom_range(0, 255));
      d = $urandom; rdat = $urandom; ird = 5'($urandom_range(1, 31));
      wn = $urandom_range(1, 4);
      run_op(ird, d, r, w, a, fn, wn, rdat);
      model_step(ird, d, r, w, a, fn, rdat);
      tests_run++;
      if (obs_req !== exp_req) begin
        tests_failed++;
        $display("FAIL rand_req[%0d]: req=%b required %b", n, obs_req, exp_req);
      end
      if (exp_req) begin
        tests_run++;
        if ({obs_rw, obs_addr, obs_be} !== {w, a & 32'hFFFFFFFC, exp_be(a, fn)} ||
            (w && obs_wdata !== exp_wdata(d, fn)) || !obs_req_ok || obs_req_after !== 1'b0 || obs_busy != wn + 1) begin
          tests_failed++;
          $display("FAIL rand_bus[%0d]: rw=%b addr=%h be=%b wdata=%h busy=%0d, required %b %h %b %h %0d",
                   n, obs_rw, obs_addr, obs_be, obs_wdata, obs_busy, w, a & 32'hFFFFFFFC, exp_be(a, fn), exp_wdata(d, fn), wn + 1);
        end
      end
      tests_run++;
      if (obs_out !== {m_tag, m_inst, m_rd, m_fault} || obs_fault_after !== 1'b0 || obs_busy_after !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: out=%h fault_next=%b, required %h fault_next=0", n, obs_out, obs_fault_after,
                 {m_tag, m_inst, m_rd, m_fault});
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    cur_tag = cur_tag + 8'd1;
    tag = cur_tag; inst_rd = 5'd4; mrd = 1'b1; mwr = 1'b0; addr = 32'h7000; f3 = 3'b010;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.request !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: req=%b required 0 before next edge", bus.request);
    end
    tag = '0; bus.ready = 1'b1; bus.rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({o_tag, o_inst_rd, o_rd, o_fault, bus.request} !== '0) begin
      tests_failed++;
      $display("FAIL reset_stale_ready: tag=%h ird=%0d rd=%h fault=%b req=%b, required all 0", o_tag, o_inst_rd, o_rd, o_fault, bus.request);
    end
    bus.ready = 1'b0;
    cur_tag = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ready = 1'b0;
    bus.rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_pass_through;
    test_load_extend;
    test_store_half;
    test_misaligned;
    test_stall;
    test_timeout;
    test_random;
    test_reset_mid_wait;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
